mem_block_responder: RTL and testbench

Main-memory responder for the 2-way data cache's miss path. Accepts block-level miss requests from the two cache access ports, performs an optional dirty-victim writeback, then reads the requested 128-bit block and returns it as a one-cycle fill pulse. This pulse drives the cache's refill strobes (store-merge refill, or read-miss refill). It models the 20-cycle main-memory latency and sits between the cache and the backing memory array.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/mem_array_128.sv | 33 +++
 rtl/mem_block_responder.sv | 133 +++++++++++++
 tb/tb_mem_block_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: block geometry, responder states and
// address field helpers used by the miss-path responder.
package cache_pkg;

    localparam int BLOCK_W = 128;
    localparam int TAG_W   = 20;
    localparam int SET_W   = 10;
    localparam int OFF_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:32-TAG_W];
    endfunction

    function automatic logic [SET_W-1:0] addr_set(input logic [31:0] a);
        return a[OFF_W+SET_W-1:OFF_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/mem_array_128.sv
// Single-port block array: synchronous write, registered read.
// Only the read register is reset; storage contents survive reset.
module mem_array_128
    import cache_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);

    logic [BLOCK_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// Miss-path main-memory responder: arbitrates two cache ports, optionally
// writes back a dirty victim, then returns the requested block as a fill pulse.
module mem_block_responder
    import cache_pkg::*;
#(
    parameter int LAT    = 20,
    parameter int MEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_valid2,
    input  logic               req_dirty,
    input  logic               req_dirty2,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_addr2,
    input  logic [TAG_W-1:0]   wb_tag,
    input  logic [TAG_W-1:0]   wb_tag2,
    input  logic [BLOCK_W-1:0] wb_data,
    input  logic [BLOCK_W-1:0] wb_data2,
    output logic               req_ack,
    output logic               req_ack2,
    output logic               fill_valid,
    output logic               fill_port,
    output logic [BLOCK_W-1:0] fill_data,
    output logic               busy
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               port_id;
    logic [MEM_AW-1:0]  rd_addr;
    logic [MEM_AW-1:0]  wb_addr;
    logic [BLOCK_W-1:0] wb_buf;

    logic               idle;
    logic               accept;
    logic               in_dirty;
    logic [31:0]        in_addr;
    logic [TAG_W-1:0]   in_tag;
    logic [BLOCK_W-1:0] in_data;
    logic [TAG_W+SET_W-1:0] wb_full;
    logic               unused_bits;

    logic               arr_we;
    logic               arr_re;
    logic [MEM_AW-1:0]  arr_addr;

    assign idle     = (state == S_IDLE);
    // Fixed priority: port 2 only wins when port 1 is silent.
    assign req_ack  = !rst && idle && req_valid;
    assign req_ack2 = !rst && idle && !req_valid && req_valid2;
    assign accept   = req_ack || req_ack2;

    assign in_dirty = req_ack2 ? req_dirty2 : req_dirty;
    assign in_addr  = req_ack2 ? req_addr2  : req_addr;
    assign in_tag   = req_ack2 ? wb_tag2    : wb_tag;
    assign in_data  = req_ack2 ? wb_data2   : wb_data;
    assign wb_full  = {in_tag, addr_set(in_addr)};

    assign unused_bits = ^{in_addr, in_tag, wb_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            port_id <= 1'b0;
            rd_addr <= '0;
            wb_addr <= '0;
            wb_buf  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        port_id <= req_ack2;
                        rd_addr <= in_addr[MEM_AW+1:2];
                        wb_addr <= wb_full[MEM_AW-1:0];
                        wb_buf  <= in_data;
                        cnt     <= CNT_LOAD;
                        state   <= in_dirty ? S_WB : S_RD;
                    end
                end
                S_WB: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_LOAD;
                        state <= S_RD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RD: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The writeback commits a full phase before the read, so a colliding
    // read naturally observes the victim data.
    assign arr_we   = !rst && (state == S_WB) && (cnt == '0);
    assign arr_re   = !rst && (state == S_RD) && (cnt == '0);
    assign arr_addr = (state == S_WB) ? wb_addr : rd_addr;

    mem_array_128 #(
        .AW(MEM_AW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .re   (arr_re),
        .addr (arr_addr),
        .wdata(wb_buf),
        .rdata(fill_data)
    );

    assign fill_valid = (state == S_DONE);
    assign fill_port  = port_id;
    assign busy       = !idle;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: LAT=20 instance plus a LAT=1 build.
module tb_mem_block_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         req_valid = 0, req_valid2 = 0;
    logic         req_dirty = 0, req_dirty2 = 0;
    logic [31:0]  req_addr = '0, req_addr2 = '0;
    logic [19:0]  wb_tag = '0, wb_tag2 = '0;
    logic [127:0] wb_data = '0, wb_data2 = '0;
    logic         req_ack, req_ack2, fill_valid, fill_port, busy;
    logic [127:0] fill_data;

    logic         v1 = 0, d1 = 0;
    logic [31:0]  a1 = '0;
    logic [19:0]  t1 = '0;
    logic [127:0] wd1 = '0;
    logic         ack1, ack1b, fv1, fp1, busy1;
    logic [127:0] fd1;

    mem_block_responder #(.LAT(20), .MEM_AW(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_valid2(req_valid2),
        .req_dirty(req_dirty), .req_dirty2(req_dirty2),
        .req_addr(req_addr), .req_addr2(req_addr2),
        .wb_tag(wb_tag), .wb_tag2(wb_tag2),
        .wb_data(wb_data), .wb_data2(wb_data2),
        .req_ack(req_ack), .req_ack2(req_ack2),
        .fill_valid(fill_valid), .fill_port(fill_port),
        .fill_data(fill_data), .busy(busy)
    );

    mem_block_responder #(.LAT(1), .MEM_AW(12)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_valid2(1'b0),
        .req_dirty(d1), .req_dirty2(1'b0),
        .req_addr(a1), .req_addr2(32'h0),
        .wb_tag(t1), .wb_tag2(20'h0),
        .wb_data(wd1), .wb_data2(128'h0),
        .req_ack(ack1), .req_ack2(ack1b),
        .fill_valid(fv1), .fill_port(fp1),
        .fill_data(fd1), .busy(busy1)
    );

    localparam logic [127:0] P5   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] P3   = 128'h33333333_33333333_33333333_33333333;
    localparam logic [127:0] P6   = 128'h66666666_77777777_88888888_99999999;
    localparam logic [127:0] A5   = {16{8'hA5}};
    localparam logic [127:0] OLD  = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
    localparam logic [127:0] COLW = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    // Issue one request in the next cycle and wait for its fill.
    // lat counts cycles from acceptance to fill_valid (-1 if none).
    task automatic run_req(input bit u, input bit p2, input bit dirty,
                           input logic [31:0] addr, input logic [19:0] tag,
                           input logic [127:0] data, output bit acked,
                           output int lat, output logic [127:0] fd,
                           output logic fp);
        @(negedge clk);
        if (u) begin
            d1 = dirty; a1 = addr; t1 = tag; wd1 = data; v1 = 1;
        end else if (p2) begin
            req_dirty2 = dirty; req_addr2 = addr; wb_tag2 = tag;
            wb_data2 = data; req_valid2 = 1;
        end else begin
            req_dirty = dirty; req_addr = addr; wb_tag = tag;
            wb_data = data; req_valid = 1;
        end
        #1;
        acked = u ? ack1 : (p2 ? req_ack2 : req_ack);
        @(negedge clk);
        v1 = 0; req_valid = 0; req_valid2 = 0;
        lat = -1; fd = '0; fp = 0;
        for (int i = 1; i <= 200; i++) begin
            #1;
            if (u ? fv1 : fill_valid) begin
                lat = i;
                fd = u ? fd1 : fill_data;
                fp = u ? fp1 : fill_port;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        @(negedge clk);
        req_valid = 1;
        @(negedge clk);
        #1;
        checks++; if (req_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", req_ack); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid got %b want 0", fill_valid); end
        checks++; if (fill_port !== 1'b0) begin errors++; $display("FAIL reset_fill_port got %b want 0", fill_port); end
        checks++; if (fill_data !== 128'h0) begin errors++; $display("FAIL reset_fill_data got %h want 0", fill_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy_lat1 got %b want 0", busy1); end
        req_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_clean_read;
        bit ok; int lat; logic [127:0] fd; logic fp;
        dut.u_array.mem[12'h005] = P5;
        run_req(0, 0, 0, 32'h0000_0014, 20'h0, '0, ok, lat, fd, fp);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clean_ack got %b want 1", ok); end
        checks++; if (lat != 21) begin errors++; $display("FAIL clean_lat got %0d want 21", lat); end
        checks++; if (fp !== 1'b0) begin errors++; $display("FAIL clean_port got %b want 0", fp); end
        checks++; if (fd !== P5) begin errors++; $display("FAIL clean_data got %h want %h", fd, P5); end
        @(negedge clk); #1;
        checks++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL clean_pulse got fv=%b busy=%b want 0 0", fill_valid, busy);
        end
    endtask

    task automatic test_dirty_miss;
        bit ok; int lat; logic [127:0] fd; logic fp;
        dut.u_array.mem[12'h003] = P3;
        dut.u_array.mem[12'h403] = '0;
        run_req(0, 0, 1, 32'h0000_000C, 20'h00001, A5, ok, lat, fd, fp);
        checks++; if (lat != 41) begin errors++; $display("FAIL dirty_lat got %0d want 41", lat); end
        checks++; if (fd !== P3) begin errors++; $display("FAIL dirty_data got %h want %h", fd, P3); end
        run_req(0, 0, 0, 32'h0000_100C, 20'h0, '0, ok, lat, fd, fp);
        checks++; if (lat != 21) begin errors++; $display("FAIL victim_lat got %0d want 21", lat); end
        checks++; if (fd !== A5) begin errors++; $display("FAIL victim_data got %h want %h", fd, A5); end
    endtask

    task automatic test_collision;
        bit ok; int lat; logic [127:0] fd; logic fp;
        dut.u_array.mem[12'h808] = OLD;
        run_req(0, 0, 1, 32'h0000_2020, 20'h00002, COLW, ok, lat, fd, fp);
        checks++; if (lat != 41) begin errors++; $display("FAIL coll_lat got %0d want 41", lat); end
        checks++; if (fd !== COLW) begin errors++; $display("FAIL coll_data got %h want %h", fd, COLW); end
    endtask

    task automatic test_priority;
        int lat;
        dut.u_array.mem[12'h006] = P6;
        @(negedge clk);
        req_dirty = 0; req_addr = 32'h14; req_valid = 1;
        req_dirty2 = 0; req_addr2 = 32'h18; req_valid2 = 1;
        #1;
        checks++; if (req_ack !== 1'b1 || req_ack2 !== 1'b0) begin
            errors++; $display("FAIL prio_acks got %b%b want 10", req_ack, req_ack2);
        end
        @(negedge clk);
        req_valid = 0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            #1;
            if (req_ack2 && lat < 0) begin lat = -2; end
            if (fill_valid) begin
                if (lat == -1) lat = i;
                break;
            end
            @(negedge clk);
        end
        checks++; if (lat != 21) begin errors++; $display("FAIL prio_p1_lat got %0d want 21", lat); end
        checks++; if (fill_port !== 1'b0) begin errors++; $display("FAIL prio_p1_port got %b want 0", fill_port); end
        @(negedge clk); #1;
        checks++; if (req_ack2 !== 1'b1) begin errors++; $display("FAIL prio_p2_ack got %b want 1", req_ack2); end
        @(negedge clk);
        req_valid2 = 0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            #1;
            if (fill_valid) begin lat = i; break; end
            @(negedge clk);
        end
        checks++; if (lat != 21) begin errors++; $display("FAIL prio_p2_lat got %0d want 21", lat); end
        checks++; if (fill_port !== 1'b1) begin errors++; $display("FAIL prio_p2_port got %b want 1", fill_port); end
        checks++; if (fill_data !== P6) begin errors++; $display("FAIL prio_p2_data got %h want %h", fill_data, P6); end
    endtask

    task automatic test_reset_mid;
        bit ok; int lat; logic [127:0] fd; logic fp; int seen;
        dut.u_array.mem[12'h010] = P3;
        dut.u_array.mem[12'hC10] = OLD;
        @(negedge clk);
        req_dirty = 1; req_addr = 32'h40; wb_tag = 20'h00003;
        wb_data = A5; req_valid = 1;
        #1;
        checks++; if (req_ack !== 1'b1) begin errors++; $display("FAIL rmid_ack got %b want 1", req_ack); end
        @(negedge clk);
        req_valid = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (fill_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_fill got %0d pulses want 0", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        run_req(0, 0, 0, 32'h0000_3040, 20'h0, '0, ok, lat, fd, fp);
        checks++; if (fd !== OLD) begin errors++; $display("FAIL rmid_victim got %h want %h", fd, OLD); end
    endtask

    task automatic test_lat1;
        bit ok; int lat; logic [127:0] fd; logic fp;
        int first, second;
        dut1.u_array.mem[12'h005] = P5;
        dut1.u_array.mem[12'h003] = P3;
        run_req(1, 0, 0, 32'h14, 20'h0, '0, ok, lat, fd, fp);
        checks++; if (lat != 2) begin errors++; $display("FAIL lat1_clean got %0d want 2", lat); end
        checks++; if (fd !== P5) begin errors++; $display("FAIL lat1_clean_data got %h want %h", fd, P5); end
        run_req(1, 0, 1, 32'h0C, 20'h00001, A5, ok, lat, fd, fp);
        checks++; if (lat != 3) begin errors++; $display("FAIL lat1_dirty got %0d want 3", lat); end
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            d1 = d[0]; a1 = 32'h14; t1 = 20'h7; wd1 = P5; v1 = 1;
            first = -1; second = -1;
            for (int i = 0; i < 12; i++) begin
                #1;
                if (ack1) begin
                    if (first < 0) first = i;
                    else if (second < 0) second = i;
                end
                @(negedge clk);
            end
            v1 = 0;
            repeat (6) @(negedge clk);
            checks++;
            if (second - first != 3 + d || first < 0) begin
                errors++;
                $display("FAIL lat1_b2b dirty=%0d got %0d want %0d", d, second - first, 3 + d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_read();
        test_dirty_miss();
        test_collision();
        test_priority();
        test_reset_mid();
        test_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
